// File: rtl/jamma_joy_scan.sv
// rtl/jamma_joy_scan.sv - JAMMA multiplexed player input scanner with per-bit debounce
module jamma_joy_scan #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8,
  parameter int SEL_W    = 1,
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          JJOY,
  input  logic [WIDTH-1:0]          local_joy,
  output logic [SEL_W-1:0]          JSELECT,
  output logic [CHANNELS*WIDTH-1:0] joy_out,
  output logic [CHANNELS-1:0]       chan_changed,
  output logic                      frame_done
);

  typedef enum logic {ST_SETTLE, ST_SAMPLE} state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0]    r_ch, w_ch_nxt;
  logic                w_sample;
  logic                w_last;
  logic [WIDTH-1:0]    r_sync1, r_sync2;
  logic [WIDTH-1:0]    r_joy  [CHANNELS];
  logic [3:0]          r_dcnt [CHANNELS][WIDTH];
  logic [WIDTH-1:0]    w_raw, w_cur, w_new;
  logic [3:0]          w_new_dcnt [WIDTH];
  logic [3:0]          w_inc;
  logic [CHANNELS-1:0] r_changed;
  logic                r_frame;

  assign w_last = (r_ch == SEL_W'(CHANNELS - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_SETTLE;
      r_cnt   <= '0;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  // Dropping enable, even on the SAMPLE cycle, discards the sample and restarts settle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_sample    = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_SETTLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == 8'(SETTLE - 1)) w_state_nxt = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          w_sample    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLE;
          w_ch_nxt    = w_last ? '0 : r_ch + 1'b1;
        end
        default: w_state_nxt = ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= JJOY;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_raw = r_sync2 & ((r_ch == '0) ? local_joy : '1);
    w_cur = r_joy[r_ch];
    w_new = w_cur;
    w_inc = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_new_dcnt[b] = '0;
      if (w_raw[b] != w_cur[b]) begin
        w_inc = r_dcnt[r_ch][b] + 4'd1;
        if (w_inc == 4'(DEBOUNCE)) begin
          w_new[b] = w_raw[b];
        end else begin
          w_new_dcnt[b] = w_inc;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_joy[c] <= '1;
        for (int b = 0; b < WIDTH; b++) r_dcnt[c][b] <= '0;
      end
      r_changed <= '0;
      r_frame   <= 1'b0;
    end else begin
      r_changed <= '0;
      r_frame   <= 1'b0;
      if (w_sample) begin
        r_joy[r_ch] <= w_new;
        for (int b = 0; b < WIDTH; b++) r_dcnt[r_ch][b] <= w_new_dcnt[b];
        r_changed[r_ch] <= (w_new != w_cur);
        r_frame         <= w_last;
      end
    end
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_out
      assign joy_out[c*WIDTH +: WIDTH] = r_joy[c];
    end
  endgenerate

  assign JSELECT      = r_ch;
  assign chan_changed = r_changed;
  assign frame_done   = r_frame;

endmodule
